// File: rtl/vga_timing_driver_if.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_driver_if
// Description : Pixel-path bundle between the VGA timing driver (slave) and
//               the renderer / colour-mux side (master).
// Revision    : 1.0 - initial release
// ============================================================================
interface vga_timing_driver_if;
    logic        pixel_en_i;
    logic [9:0]  column_o;
    logic [9:0]  row_o;
    logic        video_on_o;
    logic        frame_start_o;
    logic [11:0] rgb_i;
    logic [11:0] vga_rgb_o;
    logic        vga_hs_o;
    logic        vga_vs_o;

    modport slave (
        input  pixel_en_i,
        input  rgb_i,
        output column_o,
        output row_o,
        output video_on_o,
        output frame_start_o,
        output vga_rgb_o,
        output vga_hs_o,
        output vga_vs_o
    );

    modport master (
        output pixel_en_i,
        output rgb_i,
        input  column_o,
        input  row_o,
        input  video_on_o,
        input  frame_start_o,
        input  vga_rgb_o,
        input  vga_hs_o,
        input  vga_vs_o
    );
endinterface
`default_nettype wire

// File: rtl/vga_timing_driver.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_driver
// Description : VGA raster timing generator with sync delayed to line up with
//               the RGB returned by the colour mux.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_driver #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int RGB_LAT   = 1
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    vga_timing_driver_if.slave bus
);
    localparam int         c_H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int         c_V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam logic [9:0] c_H_LAST   = 10'(c_H_TOTAL - 1);
    localparam logic [9:0] c_V_LAST   = 10'(c_V_TOTAL - 1);
    localparam logic [9:0] c_H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] c_V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] c_HS_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] c_HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] c_VS_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] c_VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);
    // {video_on, hs, vs} with both syncs inactive
    localparam logic [2:0] c_DLY_IDLE = 3'b011;

    logic [9:0]  col_q, col_d;
    logic [9:0]  row_q, row_d;
    logic        video_on_q, video_on_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic        frame_start_q, frame_start_d;
    logic [2:0]  dly_q [RGB_LAT];
    logic [11:0] pin_rgb_q;
    logic        pin_hs_q;
    logic        pin_vs_q;

    always_comb begin
        col_d         = col_q;
        row_d         = row_q;
        frame_start_d = 1'b0;
        if (bus.pixel_en_i) begin
            if (col_q == c_H_LAST) begin
                col_d         = '0;
                row_d         = (row_q == c_V_LAST) ? '0 : row_q + 10'd1;
                frame_start_d = (row_q == c_V_LAST);
            end else begin
                col_d = col_q + 10'd1;
            end
        end
        // Decoded from the next count so the flags stay coherent with it
        video_on_d = (col_d < c_H_VIS) && (row_d < c_V_VIS);
        hs_d       = !((col_d >= c_HS_START) && (col_d < c_HS_END));
        vs_d       = !((row_d >= c_VS_START) && (row_d < c_VS_END));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q         <= '0;
            row_q         <= '0;
            video_on_q    <= 1'b0;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= frame_start_d;
            if (bus.pixel_en_i) begin
                col_q      <= col_d;
                row_q      <= row_d;
                video_on_q <= video_on_d;
                hs_q       <= hs_d;
                vs_q       <= vs_d;
            end
        end
    end

    // Free-running alignment pipe: drains to the held values while paused
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RGB_LAT; i++) begin
                dly_q[i] <= c_DLY_IDLE;
            end
            pin_rgb_q <= '0;
            pin_hs_q  <= 1'b1;
            pin_vs_q  <= 1'b1;
        end else begin
            dly_q[0] <= {video_on_q, hs_q, vs_q};
            for (int i = 1; i < RGB_LAT; i++) begin
                dly_q[i] <= dly_q[i-1];
            end
            pin_rgb_q <= dly_q[RGB_LAT-1][2] ? bus.rgb_i : 12'h000;
            pin_hs_q  <= dly_q[RGB_LAT-1][1];
            pin_vs_q  <= dly_q[RGB_LAT-1][0];
        end
    end

    assign bus.column_o      = col_q;
    assign bus.row_o         = row_q;
    assign bus.video_on_o    = video_on_q;
    assign bus.frame_start_o = frame_start_q;
    assign bus.vga_rgb_o     = pin_rgb_q;
    assign bus.vga_hs_o      = pin_hs_q;
    assign bus.vga_vs_o      = pin_vs_q;
endmodule
`default_nettype wire
